// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - state_t : FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   - WIDTH_MIN / WIDTH_MAX : legal operand width range used by parameter checks
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor built as a structural gate netlist.
//   D    = A ^ B ^ Bin
//   Bout = (~A & B) | (~(A ^ B) & Bin)
// Ports:
//   A    in  1  minuend bit
//   B    in  1  subtrahend bit
//   Bin  in  1  borrow in
//   D    out 1  difference bit
//   Bout out 1  borrow out
// -----------------------------------------------------------------------------
module full_subtractor
    import serial_sub_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    logic x_s;
    logic x_n_s;
    logic a_n_s;
    logic gen_s;
    logic prop_s;

    // Difference path: two cascaded XORs
    xor u_x1 (x_s, A, B);
    xor u_x2 (D, x_s, Bin);

    // Borrow generated locally when A=0, B=1
    not u_n1 (a_n_s, A);
    and u_a1 (gen_s, a_n_s, B);

    // Incoming borrow propagates when A and B are equal
    not u_n2 (x_n_s, x_s);
    and u_a2 (prop_s, x_n_s, Bin);

    or  u_o1 (Bout, gen_s, prop_s);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor computing D = A - B, LSB first, one bit per
// clock through a single full_subtractor cell and a registered borrow.
// Handshake: Start is accepted in IDLE or DONE; Busy is high during SHIFT;
// Done pulses for one cycle when D/Bout carry the new result.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the Ovf (signed overflow)
// output and its register.
// Ports:
//   Clk   in   1      clock, rising edge
//   Rst   in   1      asynchronous active-high reset
//   Start in   1      operation request
//   A     in   WIDTH  minuend, captured on the accepting edge
//   B     in   WIDTH  subtrahend, captured on the accepting edge
//   Busy  out  1      high while bits are processed
//   Done  out  1      one-cycle result-valid pulse
//   D     out  WIDTH  difference modulo 2^WIDTH
//   Bout  out  1      final borrow (A < B unsigned)
//   Ovf   out  1      signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of legal range");
    end

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-2:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             bor_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic             diff_s;
    logic             bnext_s;
    logic             last_s;
    logic [WIDTH-1:0] res_full_s;

    full_subtractor u_fs (
        .A    (sa_q[0]),
        .B    (sb_q[0]),
        .Bin  (bor_q),
        .D    (diff_s),
        .Bout (bnext_s)
    );

    // The partial result only needs WIDTH-1 bits: the final diff bit joins
    // them on the edge that publishes D, so no stale LSB is ever kept.
    assign res_full_s = {diff_s, res_q};
    assign last_s     = (cnt_q == CNT_LAST);

    assign Busy = busy_q;
    assign Done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_q;
`endif

    // Control FSM, operand shifters, borrow flop and registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            sa_q    <= {WIDTH{1'b0}};
            sb_q    <= {WIDTH{1'b0}};
            res_q   <= {(WIDTH-1){1'b0}};
            cnt_q   <= {CW{1'b0}};
            bor_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        sa_q    <= A;
                        sb_q    <= B;
                        bor_q   <= 1'b0;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
                    res_q <= res_full_s[WIDTH-1:1];
                    bor_q <= bnext_s;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (last_s) begin
                        d_q     <= res_full_s;
                        bout_q  <= bnext_s;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB differs from borrow out of it
                        ovf_q   <= bor_q ^ bnext_s;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor with WIDTH=8: directed vector
// table, hand-written handshake/reset sequences and a random sweep compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         Clk;
    logic         Rst;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;
`endif

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .D     (D),
        .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on integers
    function automatic logic [W-1:0] ref_d(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned diff;
        diff = (int'(a) - int'(b) + 256) % 256;
        return diff[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b);
        return (int'(a) < int'(b));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        int sd;
        sd = int'($signed(a)) - int'($signed(b));
        return (sd < -128) || (sd > 127);
    endfunction

    // Called at a negedge; counts samples until Done (lat=0 if never seen)
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int i = 1; i <= 30; i++) begin
            if (Busy && Done) overlap++;
            if (Busy) nbusy++;
            if (Done) begin
                lat = i;
                break;
            end
            @(negedge Clk);
        end
    endtask

    // Called at a negedge; pulses Start for one edge and waits for Done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy);
        A     = a;
        B     = b;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(lat, nbusy);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int   lat;
        int   nbusy;
        int   ndone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
        vecs[8] = '{8'h01, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

        Rst   = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge Clk);

        check("reset_busy", Busy, 1'b0);
        check("reset_done", Done, 1'b0);
        check("reset_d",    D,    8'h00);
        check("reset_bout", Bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf",  Ovf,  1'b0);
`endif
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        check("idle_busy", Busy, 1'b0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, nbusy);
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_busy_cycles", i), nbusy, 8);
            check($sformatf("vec%0d_d", i), D, vecs[i].d);
            check($sformatf("vec%0d_bout", i), Bout, vecs[i].bout);
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("vec%0d_ovf", i), Ovf, vecs[i].ovf);
`endif
            @(negedge Clk);
            check($sformatf("vec%0d_done_pulse", i), Done, 1'b0);
            check($sformatf("vec%0d_d_hold", i), D, vecs[i].d);
        end

        // Start during SHIFT is ignored, then back-to-back Start in DONE
        A = 8'h5A; B = 8'h3C; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        A = 8'h11; B = 8'h22; Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        wait_done(lat, nbusy);
        check("ignore_latency", lat, 5);
        check("ignore_d", D, 8'h1E);
        check("ignore_bout", Bout, 1'b0);
        A = 8'hFF; B = 8'hFF; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("b2b_busy_after_accept", Busy, 1'b1);
        wait_done(lat, nbusy);
        check("b2b_latency", lat, 9);
        check("b2b_d", D, 8'h00);
        check("b2b_bout", Bout, 1'b0);
        @(negedge Clk);

        // Asynchronous reset after four SHIFT edges
        run_op(8'h5A, 8'h3C, lat, nbusy);
        check("pre_rst_d", D, 8'h1E);
        @(negedge Clk);
        A = 8'h77; B = 8'h11; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        check("pre_rst_busy", Busy, 1'b1);
        #2 Rst = 1'b1;
        #1;
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_d", D, 8'h00);
        @(negedge Clk);
        Rst   = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge Clk);
            if (Done) ndone++;
        end
        check("rst_no_done", ndone, 0);
        check("rst_d_hold", D, 8'h00);
        run_op(8'h10, 8'h20, lat, nbusy);
        check("post_rst_latency", lat, 9);
        check("post_rst_d", D, 8'hF0);
        check("post_rst_bout", Bout, 1'b1);
        @(negedge Clk);

        // Random sweep against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, lat, nbusy);
            check($sformatf("rnd%0d_d a=%0h b=%0h", n, ra, rb), D, ref_d(ra, rb));
            check($sformatf("rnd%0d_bout a=%0h b=%0h", n, ra, rb), Bout, ref_bout(ra, rb));
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("rnd%0d_ovf a=%0h b=%0h", n, ra, rb), Ovf, ref_ovf(ra, rb));
`endif
            if (n % 2 == 0) @(negedge Clk);
        end

        check("busy_done_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
